// File: rtl/bird_pkg.sv
// Shared types and fixed-point constants for the bird motion controller.
package bird_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLYING = 2'd1,
        DYING  = 2'd2,
        OVER   = 2'd3
    } bird_state_e;

    localparam int HIT_LEFT   = 3;
    localparam int HIT_TOP    = 2;
    localparam int HIT_RIGHT  = 1;
    localparam int HIT_BOTTOM = 0;

    localparam int FP_SHIFT = 6;
    localparam int Y_FP_W   = 17;
    localparam int SPEED_W  = 12;

endpackage

// File: rtl/bird_motion_ctrl_if.sv
// Frame/event inputs and position/visibility outputs of the bird motion controller.
interface bird_motion_ctrl_if;

    logic               startOfFrame;
    logic               flapPulse;
    logic               restartPulse;
    logic               collision;
    logic [3:0]         HitEdgeCode;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               showBird;
    logic               birdDead;
    logic [3:0]         hitEdges;

    modport master (
        output startOfFrame, flapPulse, restartPulse, collision, HitEdgeCode,
        input  topLeftX, topLeftY, showBird, birdDead, hitEdges
    );

    modport slave (
        input  startOfFrame, flapPulse, restartPulse, collision, HitEdgeCode,
        output topLeftX, topLeftY, showBird, birdDead, hitEdges
    );

endinterface

// File: rtl/bird_hit_accumulator.sv
// Per-frame OR-latch of flap and collision events; the snapshot includes the
// current cycle so events coincident with startOfFrame close out the old frame.
module bird_hit_accumulator (
    input  logic       clk,
    input  logic       reset,
    input  logic       sof,
    input  logic       restart,
    input  logic       flap_pulse,
    input  logic       collision,
    input  logic [3:0] hit_edge_code,
    output logic       snap_flap,
    output logic       snap_hit,
    output logic [3:0] snap_edges
);

    logic       flap_q;
    logic       hit_q;
    logic [3:0] edges_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flap_q  <= 1'b0;
            hit_q   <= 1'b0;
            edges_q <= '0;
        end else if (restart || sof) begin
            flap_q  <= 1'b0;
            hit_q   <= 1'b0;
            edges_q <= '0;
        end else begin
            flap_q  <= snap_flap;
            hit_q   <= snap_hit;
            edges_q <= snap_edges;
        end
    end

    assign snap_flap  = flap_q | flap_pulse;
    assign snap_hit   = hit_q | collision;
    assign snap_edges = edges_q | (collision ? hit_edge_code : 4'b0000);

endmodule

// File: rtl/bird_motion_ctrl.sv
// Game-state FSM with once-per-frame flap/gravity physics for the bird sprite.
//
// state  | meaning
// IDLE   | waiting at start position for the first flap
// FLYING | physics active, collisions and floor are fatal
// DYING  | frozen, blinking for DEAD_FRAMES frames
// OVER   | hidden and frozen until restart
module bird_motion_ctrl
    import bird_pkg::*;
#(
    parameter int INITIAL_X    = 160,
    parameter int INITIAL_Y    = 200,
    parameter int GRAVITY      = 16,
    parameter int FLAP_SPEED   = 256,
    parameter int MAX_FALL     = 512,
    parameter int FLOOR_Y      = 448,
    parameter int DEAD_FRAMES  = 60,
    parameter int BLINK_FRAMES = 8
) (
    input  logic               clk,
    input  logic               reset,
    bird_motion_ctrl_if.slave  bus
);

    localparam int DEAD_W  = $clog2(DEAD_FRAMES + 1);
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

    localparam logic signed [Y_FP_W-1:0]  Y_START    = Y_FP_W'(INITIAL_Y << FP_SHIFT);
    localparam logic signed [Y_FP_W-1:0]  Y_FLOOR    = Y_FP_W'(FLOOR_Y << FP_SHIFT);
    localparam logic signed [Y_FP_W:0]    Y_SUM_MAX  = (Y_FP_W+1)'((1 << (Y_FP_W-1)) - 1);
    localparam logic signed [Y_FP_W:0]    Y_SUM_MIN  = (Y_FP_W+1)'(-(1 << (Y_FP_W-1)));
    localparam logic signed [SPEED_W:0]   GRAV_W     = (SPEED_W+1)'(GRAVITY);
    localparam logic signed [SPEED_W:0]   MAX_FALL_W = (SPEED_W+1)'(MAX_FALL);
    localparam logic signed [SPEED_W-1:0] FLAP_W     = SPEED_W'(-FLAP_SPEED);
    localparam logic [DEAD_W-1:0]         DEAD_LOAD  = DEAD_W'(DEAD_FRAMES);
    localparam logic [BLINK_W-1:0]        BLINK_LOAD = BLINK_W'(BLINK_FRAMES);

    bird_state_e                state_q, state_d;
    logic signed [Y_FP_W-1:0]   y_q, y_d;
    logic signed [SPEED_W-1:0]  spd_q, spd_d;
    logic [DEAD_W-1:0]          dead_q, dead_d, dead_n;
    logic [BLINK_W-1:0]         blink_q, blink_d, blink_n;
    logic                       show_q, show_d;
    logic [3:0]                 hit_q, hit_d;

    logic                       sof, restart;
    logic                       snap_flap, snap_hit;
    logic [3:0]                 snap_edges;

    logic signed [SPEED_W:0]    spd_grav;
    logic signed [SPEED_W-1:0]  spd_new;
    logic signed [Y_FP_W:0]     y_sum;
    logic signed [Y_FP_W-1:0]   y_sat;
    logic signed [Y_FP_W-1:0]   phys_y;
    logic signed [SPEED_W-1:0]  phys_spd;
    logic                       phys_floor;

    assign sof     = bus.startOfFrame;
    assign restart = bus.restartPulse;

    bird_hit_accumulator u_acc (
        .clk           (clk),
        .reset         (reset),
        .sof           (sof),
        .restart       (restart),
        .flap_pulse    (bus.flapPulse),
        .collision     (bus.collision),
        .hit_edge_code (bus.HitEdgeCode),
        .snap_flap     (snap_flap),
        .snap_hit      (snap_hit),
        .snap_edges    (snap_edges)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            y_q     <= Y_START;
            spd_q   <= '0;
            dead_q  <= DEAD_LOAD;
            blink_q <= BLINK_LOAD;
            show_q  <= 1'b1;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            spd_q   <= spd_d;
            dead_q  <= dead_d;
            blink_q <= blink_d;
            show_q  <= show_d;
            hit_q   <= hit_d;
        end
    end

    // One frame of physics: widened sums are saturated before ceiling/floor clamps.
    always_comb begin
        spd_grav = {spd_q[SPEED_W-1], spd_q} + GRAV_W;
        if (snap_flap)
            spd_new = FLAP_W;
        else if (spd_grav > MAX_FALL_W)
            spd_new = MAX_FALL_W[SPEED_W-1:0];
        else
            spd_new = spd_grav[SPEED_W-1:0];

        y_sum = {y_q[Y_FP_W-1], y_q} + {{(Y_FP_W+1-SPEED_W){spd_new[SPEED_W-1]}}, spd_new};
        if (y_sum > Y_SUM_MAX)
            y_sat = Y_SUM_MAX[Y_FP_W-1:0];
        else if (y_sum < Y_SUM_MIN)
            y_sat = Y_SUM_MIN[Y_FP_W-1:0];
        else
            y_sat = y_sum[Y_FP_W-1:0];

        phys_y     = y_sat;
        phys_spd   = spd_new;
        phys_floor = 1'b0;
        if (y_sat[Y_FP_W-1]) begin
            phys_y   = '0;
            phys_spd = '0;
        end else if (y_sat >= Y_FLOOR) begin
            phys_y     = Y_FLOOR;
            phys_floor = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        spd_d   = spd_q;
        dead_d  = dead_q;
        blink_d = blink_q;
        show_d  = show_q;
        hit_d   = hit_q;
        dead_n  = dead_q - 1'b1;
        blink_n = blink_q - 1'b1;

        if (restart) begin
            state_d = IDLE;
            y_d     = Y_START;
            spd_d   = '0;
            dead_d  = DEAD_LOAD;
            blink_d = BLINK_LOAD;
            show_d  = 1'b1;
            hit_d   = '0;
        end else if (sof) begin
            unique case (state_q)
                IDLE, FLYING: begin
                    if (state_q == FLYING && snap_hit) begin
                        state_d = DYING;
                        hit_d   = snap_edges;
                        dead_d  = DEAD_LOAD;
                        blink_d = BLINK_LOAD;
                    end else if (state_q == FLYING || snap_flap) begin
                        state_d = FLYING;
                        y_d     = phys_y;
                        spd_d   = phys_spd;
                        if (phys_floor) begin
                            state_d           = DYING;
                            hit_d             = '0;
                            hit_d[HIT_BOTTOM] = 1'b1;
                            dead_d            = DEAD_LOAD;
                            blink_d           = BLINK_LOAD;
                        end
                    end
                end
                DYING: begin
                    dead_d  = dead_n;
                    blink_d = blink_n;
                    if (dead_n == '0) begin
                        state_d = OVER;
                        show_d  = 1'b0;
                    end else if (blink_n == '0) begin
                        show_d  = ~show_q;
                        blink_d = BLINK_LOAD;
                    end
                end
                OVER: ;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.topLeftX = 11'(INITIAL_X);
        bus.topLeftY = y_q[Y_FP_W-1:FP_SHIFT];
        bus.showBird = show_q;
        bus.birdDead = (state_q == DYING) || (state_q == OVER);
        bus.hitEdges = hit_q;
    end

endmodule

// File: doc/bird_motion_ctrl.md
Name: bird_motion_ctrl

Overview:
- Consumer of the bird drawer's collision side. Accumulates per-pixel collision pulses and HitEdgeCode over a frame, applies flap/gravity physics once per frame, and produces the bird's top-left position and visibility.
- Sits between the collision detector / key debouncer and the square-object position generator feeding the bird bitmap.
- Runs a game-state FSM: IDLE, FLYING, DYING (blink), OVER (hidden).

Parameters:
- INITIAL_X, 160, fixed bird X (pixels).
- INITIAL_Y, 200, start/restart Y (pixels).
- FP_SHIFT, 6, fixed-point fraction bits (1 px = 64 units).
- GRAVITY, 16, speed increment per frame (fp units).
- FLAP_SPEED, 256, upward speed set by a flap (fp units/frame).
- MAX_FALL, 512, downward speed clamp (fp units/frame).
- FLOOR_Y, 448, topLeftY at or above which the bird dies.
- DEAD_FRAMES, 60, length of DYING in frames.
- BLINK_FRAMES, 8, showBird toggle period in DYING (frames).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- startOfFrame  in  1  one-cycle pulse per frame
- flapPulse  in  1  one-cycle pulse per key press
- restartPulse  in  1  one-cycle pulse, returns to IDLE
- collision  in  1  bird pixel overlaps an obstacle pixel (per pixel)
- HitEdgeCode  in  4  {Left,Top,Right,Bottom} from bird bitmap, valid with collision
- topLeftX  out  11  signed, bird X
- topLeftY  out  11  signed, bird Y = Y_fp >>> FP_SHIFT
- showBird  out  1  bird visibility
- birdDead  out  1  high in DYING and OVER
- hitEdges  out  4  OR of edges that caused death, held until restart

Behaviour:
- Reset: state=IDLE; Y_fp=INITIAL_Y<<FP_SHIFT; speed=0; topLeftX=INITIAL_X; topLeftY=INITIAL_Y; showBird=1; birdDead=0; hitEdges=0; frame counter=0; pending flap/hit latches cleared.
- Internal widths: Y_fp is 17-bit signed and speed is 12-bit signed. Sums are computed one bit wider and then saturated.
- Frame accumulation (every cycle):
  - flapPending |= flapPulse.
  - hitAcc |= (collision ? HitEdgeCode : 0).
  - anyHit |= collision.
  - Events arriving in the same cycle as startOfFrame belong to the closing frame.
- Frame update happens on startOfFrame. Outputs are registered, so latency is 1 cycle after the pulse. All latches clear in the same cycle.
- IDLE: position frozen, showBird=1. If flapPending, go to FLYING and apply the flap physics this frame.
- FLYING:
  - Step 1, hit check: if anyHit, hitEdges<=hitAcc, go to DYING, position frozen. This takes priority over flap.
  - Step 2, speed: flap gives speed=-FLAP_SPEED; otherwise speed=min(speed+GRAVITY, MAX_FALL).
  - Step 3, position: Y_fp += new speed.
  - Step 4, ceiling: if Y_fp<0, then Y_fp=0 and speed=0.
  - Step 5, floor: if (Y_fp>>>FP_SHIFT) >= FLOOR_Y, clamp Y to FLOOR_Y, set hitEdges=4'b0001, go to DYING.
- DYING:
  - birdDead=1; counter increments each frame.
  - showBird toggles whenever counter % BLINK_FRAMES == 0 (counter≠0).
  - At counter==DEAD_FRAMES, go to OVER with showBird=0.
  - Flaps and collisions are ignored.
- OVER: showBird=0, birdDead=1, nothing moves.
- restartPulse (any state, any cycle) has the highest priority and takes effect next cycle:
  - Restores the reset values of the state and all outputs.
  - Clears latches, including any event in the same cycle.
  - Overrides a coincident startOfFrame.
- reset mid-frame discards pending events.

Decomposition:
- Package bird_pkg:
  - state enum {IDLE,FLYING,DYING,OVER}
  - HIT_LEFT/TOP/RIGHT/BOTTOM bit indices
  - FP_SHIFT
  - Y_FP_W=17, SPEED_W=12
- Sub-module bird_hit_accumulator: per-frame OR-latch of collision, HitEdgeCode and flap. Clears on startOfFrame or restart, and outputs a snapshot at startOfFrame.

Test Plan:
- Reset, then 3 frames with no input → topLeftY=200, topLeftX=160, showBird=1, state IDLE.
- flap, SOF → next cycle topLeftY=196 and speed=-256. Next SOF → speed=-240, Y_fp=12304, topLeftY=192.
- FLYING with collision + HitEdgeCode=4'b0100 mid-frame, a second collision with 4'b0001, then SOF → hitEdges=4'b0101, birdDead=1, Y frozen. After 8 SOFs → showBird=0. After 60 SOFs → OVER, showBird=0.
- Fall from Y=440 at MAX_FALL (8 px/frame) → on the SOF where Y reaches ≥448: topLeftY=448, hitEdges=4'b0001, DYING.
- Y=2 with flap → Y_fp would go negative → topLeftY=0, speed=0, remains FLYING.
- restartPulse in the same cycle as SOF while DYING → next cycle IDLE, topLeftY=200, showBird=1, birdDead=0, hitEdges=0.
